uart_cmd_assembler: RTL and testbench

//  Sits directly downstream of uart_rx. Collects received bytes into a line buffer.

---
 rtl/uart_cmd_assembler_if.sv | 42 ++++
 rtl/uart_cmd_assembler.sv | 146 ++++++++++++++
 tb/tb_uart_cmd_assembler.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_assembler_if.sv
// uart_cmd_assembler_if: byte strobe, command, read-port and status bundle.
// Modports: master = uart_rx/decoder side, slave = assembler.
interface uart_cmd_assembler_if #(
  parameter int MAX_LEN = 32
);
  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int ADDR_W = $clog2(MAX_LEN);

  logic              data_ready;
  logic [7:0]        data;
  logic              cmd_valid;
  logic [LEN_W-1:0]  cmd_len;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              cmd_ack;
  logic              overflow;
  logic [7:0]        dropped_cnt;

  modport master (
    output data_ready,
    output data,
    output rd_addr,
    output cmd_ack,
    input  cmd_valid,
    input  cmd_len,
    input  rd_data,
    input  overflow,
    input  dropped_cnt
  );

  modport slave (
    input  data_ready,
    input  data,
    input  rd_addr,
    input  cmd_ack,
    output cmd_valid,
    output cmd_len,
    output rd_data,
    output overflow,
    output dropped_cnt
  );
endinterface

// File: rtl/uart_cmd_assembler.sv
// uart_cmd_assembler: gathers uart_rx bytes into a line buffer and holds a
// complete command for the decoder until acked.
// Ports: clk, rst (async, active-high), bus (slave modport):
//   data_ready/data in; cmd_valid/cmd_len out; rd_addr in, rd_data out
//   (registered, 1 cycle); cmd_ack in; overflow pulse; dropped_cnt.
// Build option: define UART_CMD_BACKSPACE_EN to make 8'h08/8'h7F erase
// the last collected byte instead of being stored.
module uart_cmd_assembler #(
  parameter int         MAX_LEN  = 32,
  parameter logic [7:0] EOL_CHAR = 8'h0A
) (
  input logic                  clk,
  input logic                  rst,
  uart_cmd_assembler_if.slave  bus
);
  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int ADDR_W = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] FULL = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ZERO = '0;
  localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);

`ifdef UART_CMD_BACKSPACE_EN
  localparam bit BS_EN = 1'b1;
`else
  localparam bit BS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    COLLECT,
    READY,
    DISCARD
  } state_t;

  state_t           state, state_n;
  logic [LEN_W-1:0] count, count_n;
  logic             valid_q, valid_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic             ovf_q, ovf_n;
  logic [7:0]       drop_q, drop_n;
  logic             wr_en;
  logic [7:0]       rd_q;

  logic [7:0] mem [MAX_LEN];

  logic is_cr, is_eol, is_bs, is_txt;
  logic empty, full;

  assign is_cr  = bus.data == 8'h0D;
  assign is_eol = bus.data == EOL_CHAR;
  assign is_bs  = BS_EN &&
                  (bus.data == 8'h08 || bus.data == 8'h7F);
  assign is_txt = !is_cr && !is_eol && !is_bs;
  assign empty  = count == ZERO;
  assign full   = count == FULL;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= COLLECT;
      count   <= '0;
      valid_q <= 1'b0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      valid_q <= valid_n;
      len_q   <= len_n;
      ovf_q   <= ovf_n;
      drop_q  <= drop_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    valid_n = valid_q;
    len_n   = len_q;
    ovf_n   = 1'b0;
    drop_n  = drop_q;
    wr_en   = 1'b0;
    unique case (state)
      COLLECT: begin
        if (bus.data_ready) begin
          unique case (1'b1)
            is_cr: ;
            is_eol && empty: ;
            is_eol && !empty: begin
              valid_n = 1'b1;
              len_n   = count;
              state_n = READY;
            end
            is_bs && empty: ;
            is_bs && !empty:
              count_n = count - ONE;
            is_txt && !full: begin
              wr_en   = 1'b1;
              count_n = count + ONE;
            end
            is_txt && full: begin
              ovf_n   = 1'b1;
              state_n = DISCARD;
            end
            default: ;
          endcase
        end
      end
      DISCARD: begin
        if (bus.data_ready && is_eol) begin
          count_n = '0;
          state_n = COLLECT;
        end
      end
      READY: begin
        // Bytes arriving while a command is held are lost but counted.
        if (bus.data_ready && drop_q != 8'hFF)
          drop_n = drop_q + 8'd1;
        if (bus.cmd_ack) begin
          valid_n = 1'b0;
          len_n   = '0;
          count_n = '0;
          state_n = COLLECT;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[count[ADDR_W-1:0]] <= bus.data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_q <= '0;
    else
      rd_q <= mem[bus.rd_addr];
  end

  assign bus.cmd_valid   = valid_q;
  assign bus.cmd_len     = len_q;
  assign bus.overflow    = ovf_q;
  assign bus.dropped_cnt = drop_q;
  assign bus.rd_data     = rd_q;
endmodule

// File: tb/tb_uart_cmd_assembler.sv
// tb_uart_cmd_assembler: directed scenarios plus randomized byte traffic
// checked against a queue-based line model.
module tb_uart_cmd_assembler;
  localparam int MAX = 32;
  localparam logic [7:0] EOL = 8'h0A;
`ifdef UART_CMD_BACKSPACE_EN
  localparam bit BS = 1'b1;
`else
  localparam bit BS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_assembler_if #(.MAX_LEN(MAX)) bus ();

  uart_cmd_assembler #(.MAX_LEN(MAX), .EOL_CHAR(EOL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] line [$];
  bit held = 0;
  bit disc = 0;
  int drop = 0;
  int ovf_exp = 0;
  int ovf_obs = 0;

  task automatic model_reset();
    line.delete();
    held = 0;
    disc = 0;
    drop = 0;
  endtask

  task automatic model_step(bit dr, logic [7:0] b, bit ack);
    if (held) begin
      if (dr && drop < 255) drop++;
      if (ack) begin
        held = 0;
        line.delete();
      end
    end else if (dr) begin
      if (disc) begin
        if (b == EOL) begin
          disc = 0;
          line.delete();
        end
      end else if (b == 8'h0D) begin
      end else if (b == EOL) begin
        if (line.size() > 0) held = 1;
      end else if (BS && (b == 8'h08 || b == 8'h7F)) begin
        if (line.size() > 0) void'(line.pop_back());
      end else if (line.size() < MAX) begin
        line.push_back(b);
      end else begin
        disc = 1;
        ovf_exp++;
      end
    end
  endtask

  task automatic send(bit dr, logic [7:0] b, bit ack);
    @(negedge clk);
    bus.data_ready = dr;
    bus.data = b;
    bus.cmd_ack = ack;
    @(negedge clk);
    bus.data_ready = 1'b0;
    bus.cmd_ack = 1'b0;
    model_step(dr, b, ack);
    if (bus.overflow === 1'b1) ovf_obs++;
  endtask

  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) send(1'b1, s[i], 1'b0);
  endtask

  task automatic rd(int a, output logic [7:0] v);
    @(negedge clk);
    bus.rd_addr = a[4:0];
    @(negedge clk);
    v = bus.rd_data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.cmd_valid !== 1'b0 || bus.cmd_len !== 6'd0) begin
      n_err++;
      $display("FAIL reset_cmd got v=%b l=%0d want 0/0",
               bus.cmd_valid, bus.cmd_len);
    end
    n_cmp++;
    if (bus.overflow !== 1'b0 || bus.dropped_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL reset_stat got o=%b d=%0d want 0/0",
               bus.overflow, bus.dropped_cnt);
    end
    n_cmp++;
    if (bus.rd_data !== 8'd0) begin
      n_err++;
      $display("FAIL reset_rd got %h want 00", bus.rd_data);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    logic [7:0] v;
    logic [7:0] exp_s [4] = '{8'h4C, 8'h45, 8'h44, 8'h31};
    send_str("LED1\n");
    n_cmp++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_len !== 6'd4) begin
      n_err++;
      $display("FAIL basic_cmd got v=%b l=%0d want 1/4",
               bus.cmd_valid, bus.cmd_len);
    end
    for (int i = 0; i < 4; i++) begin
      rd(i, v);
      n_cmp++;
      if (v !== exp_s[i]) begin
        n_err++;
        $display("FAIL basic_rd[%0d] got %h want %h", i, v, exp_s[i]);
      end
    end
    send(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (bus.cmd_valid !== 1'b0 || bus.cmd_len !== 6'd0) begin
      n_err++;
      $display("FAIL basic_ack got v=%b l=%0d want 0/0",
               bus.cmd_valid, bus.cmd_len);
    end
  endtask

  task automatic test_empty();
    logic [7:0] v;
    send_str("\n\r\n");
    n_cmp++;
    if (bus.cmd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL empty_valid got %b want 0", bus.cmd_valid);
    end
    send_str("Q\n");
    n_cmp++;
    if (bus.cmd_len !== 6'd1) begin
      n_err++;
      $display("FAIL empty_len got %0d want 1", bus.cmd_len);
    end
    rd(0, v);
    n_cmp++;
    if (v !== 8'h51) begin
      n_err++;
      $display("FAIL empty_rd got %h want 51", v);
    end
    send(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_overflow();
    logic [7:0] v;
    int o0;
    o0 = ovf_obs;
    repeat (33) send(1'b1, 8'h41, 1'b0);
    send_str("\n");
    n_cmp++;
    if (ovf_obs - o0 !== 1) begin
      n_err++;
      $display("FAIL ovf_pulses got %0d want 1", ovf_obs - o0);
    end
    n_cmp++;
    if (bus.cmd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_valid got %b want 0", bus.cmd_valid);
    end
    send_str("OK\n");
    n_cmp++;
    if (bus.cmd_len !== 6'd2) begin
      n_err++;
      $display("FAIL ovf_next_len got %0d want 2", bus.cmd_len);
    end
    rd(1, v);
    n_cmp++;
    if (v !== 8'h4B) begin
      n_err++;
      $display("FAIL ovf_next_rd got %h want 4B", v);
    end
    send(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < MAX; i++) send(1'b1, 8'h61 + 8'(i % 26), 1'b0);
    send_str("\n");
    n_cmp++;
    if (bus.cmd_len !== 6'd32 || bus.cmd_valid !== 1'b1) begin
      n_err++;
      $display("FAIL full_len got v=%b l=%0d want 1/32",
               bus.cmd_valid, bus.cmd_len);
    end
    rd(31, v);
    n_cmp++;
    if (v !== 8'h66) begin
      n_err++;
      $display("FAIL full_rd31 got %h want 66", v);
    end
    send(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_held();
    logic [7:0] v0, v1;
    send_str("AB\n");
    send_str("CD\n");
    n_cmp++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_len !== 6'd2) begin
      n_err++;
      $display("FAIL held_cmd got v=%b l=%0d want 1/2",
               bus.cmd_valid, bus.cmd_len);
    end
    rd(0, v0);
    rd(1, v1);
    n_cmp++;
    if (v0 !== 8'h41 || v1 !== 8'h42) begin
      n_err++;
      $display("FAIL held_rd got %h%h want 4142", v0, v1);
    end
    n_cmp++;
    if (bus.dropped_cnt !== 8'd3) begin
      n_err++;
      $display("FAIL held_drop got %0d want 3", bus.dropped_cnt);
    end
    send(1'b1, 8'h58, 1'b1);
    n_cmp++;
    if (bus.dropped_cnt !== 8'd4 || bus.cmd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ack_drop got d=%0d v=%b want 4/0",
               bus.dropped_cnt, bus.cmd_valid);
    end
  endtask

  task automatic test_backspace();
    logic [7:0] v;
    send_str("ABX");
    send(1'b1, 8'h08, 1'b0);
    send_str("C\n");
    n_cmp++;
    if (bus.cmd_len !== (BS ? 6'd3 : 6'd5)) begin
      n_err++;
      $display("FAIL bs_len got %0d want %0d", bus.cmd_len, BS ? 3 : 5);
    end
    rd(2, v);
    n_cmp++;
    if (v !== (BS ? 8'h43 : 8'h58)) begin
      n_err++;
      $display("FAIL bs_rd2 got %h want %h", v, BS ? 8'h43 : 8'h58);
    end
    rd(3, v);
    if (!BS) begin
      n_cmp++;
      if (v !== 8'h08) begin
        n_err++;
        $display("FAIL bs_rd3 got %h want 08", v);
      end
    end
    send(1'b0, 8'h00, 1'b1);
    send(1'b1, 8'h7F, 1'b0);
    send_str("K\n");
    n_cmp++;
    if (bus.cmd_len !== 6'(line.size())) begin
      n_err++;
      $display("FAIL bs_empty_len got %0d want %0d",
               bus.cmd_len, line.size());
    end
    send(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_saturate();
    send_str("S\n");
    repeat (300) send(1'b1, 8'h55, 1'b0);
    n_cmp++;
    if (bus.dropped_cnt !== 8'hFF || drop != 255) begin
      n_err++;
      $display("FAIL drop_sat got %0d want 255", bus.dropped_cnt);
    end
    send(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_mid_reset();
    logic [7:0] v;
    send_str("AB");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.dropped_cnt !== 8'd0 || bus.cmd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_out got d=%0d v=%b want 0/0",
               bus.dropped_cnt, bus.cmd_valid);
    end
    rst = 1'b0;
    model_reset();
    send_str("Z\n");
    n_cmp++;
    if (bus.cmd_len !== 6'd1 || bus.dropped_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL midrst_len got l=%0d d=%0d want 1/0",
               bus.cmd_len, bus.dropped_cnt);
    end
    rd(0, v);
    n_cmp++;
    if (v !== 8'h5A) begin
      n_err++;
      $display("FAIL midrst_rd got %h want 5A", v);
    end
    send(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_random();
    logic [7:0] b, v;
    bit dr, ack;
    int r, a;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 19);
      case (r)
        0, 1:    b = EOL;
        2:       b = 8'h0D;
        3:       b = 8'h08;
        4:       b = 8'h7F;
        default: b = 8'h41 + 8'($urandom_range(0, 25));
      endcase
      dr  = $urandom_range(0, 3) != 0;
      ack = held ? ($urandom_range(0, 5) == 0)
                 : ($urandom_range(0, 15) == 0);
      send(dr, b, ack);
      n_cmp++;
      if (bus.cmd_valid !== held ||
          bus.cmd_len !== (held ? 6'(line.size()) : 6'd0)) begin
        n_err++;
        $display("FAIL rand_cmd[%0d] got v=%b l=%0d want %b/%0d", n,
                 bus.cmd_valid, bus.cmd_len, held,
                 held ? line.size() : 0);
      end
      n_cmp++;
      if (bus.dropped_cnt !== 8'(drop) || ovf_obs != ovf_exp) begin
        n_err++;
        $display("FAIL rand_stat[%0d] got d=%0d o=%0d want %0d/%0d",
                 n, bus.dropped_cnt, ovf_obs, drop, ovf_exp);
      end
      if (held && $urandom_range(0, 2) == 0) begin
        a = $urandom_range(0, line.size() - 1);
        rd(a, v);
        n_cmp++;
        if (v !== line[a]) begin
          n_err++;
          $display("FAIL rand_rd[%0d] got %h want %h", a, v, line[a]);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bus.data_ready = 1'b0;
    bus.data = 8'h00;
    bus.cmd_ack = 1'b0;
    bus.rd_addr = '0;
    test_reset();
    test_basic();
    test_empty();
    test_overflow();
    test_held();
    test_backspace();
    test_saturate();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
